cpu_lsu: RTL
============

// Module: cpu_lsu
// PURPOSE
//  Parametrised load/store unit between the CPU core and the data bus. Accepts one
//  REG_W-wide load/store request and runs it as BEATS = REG_W/BUS_W stb/ack bus
//  cycles, replacing fixed hi/lo half-select with a sequenced multi-beat transfer.
//  Returns assembled load data or store completion to the core as a one-cycle response.
// PARAMETERS
//  BUS_W        16   data bus width (data_data_i/o)
//  REG_W        32   core register width; integer multiple of BUS_W, BEATS >= 1
//  ADDR_W       16   word address width on core and bus side
//  TIMEOUT_CYC  255  max cycles per beat waiting for ack (CPU_LSU_TIMEOUT_EN only)
// PORTS
//  sys_clk      in   1       clock, all state on rising edge
//  sys_rst      in   1       reset, asynchronous, active-low
//  req_valid    in   1       core request valid
//  req_ready    out  1       unit idle, request accepted when valid & ready
//  req_we       in   1       1 = store, 0 = load
//  req_addr     in   ADDR_W  word address of beat 0
//  req_wdata    in   REG_W   store data
//  resp_valid   out  1       one-cycle completion pulse
//  resp_rdata   out  REG_W   assembled load data (valid with resp_valid, loads only)
//  resp_err     out  1       timeout abort flag (valid with resp_valid)
//  data_addr_o  out  ADDR_W  bus address
//  data_data_o  out  BUS_W   bus write data
//  data_data_i  in   BUS_W   bus read data
//  data_stb_o   out  1       bus strobe
//  data_we_o    out  1       bus write enable
//  data_ack_i   in   1       bus acknowledge
// BEHAVIOUR
//  - States: IDLE -> BUS -> DONE -> IDLE. req_ready = (state==IDLE), combinational.
//  - Reset: state IDLE; data_stb_o, data_we_o, resp_valid, resp_err = 0;
//    data_addr_o, data_data_o, resp_rdata, beat counter = 0. Reset mid-transfer drops
//    stb immediately; transfer discarded, no resp_valid.
//  - IDLE: on req_valid & req_ready latch we/addr/wdata, beat=0; next cycle BUS with
//    stb=1, we=req_we, addr=req_addr, data_data_o=req_wdata[BUS_W-1:0].
//  - BUS: stb held high, addr/data stable until data_ack_i sampled high. On ack of
//    beat b: loads capture data_data_i into resp_rdata[b*BUS_W +: BUS_W]; if b<BEATS-1
//    next cycle presents beat b+1 (stb stays high, addr = req_addr+b+1 mod 2^ADDR_W,
//    data = wdata slice b+1); if last beat, stb/we drop next cycle, state DONE.
//  - DONE: resp_valid=1 for exactly one cycle, then IDLE. No response backpressure.
//  - Latency with zero-wait ack: accept at cycle 0, beats at 1..BEATS, resp_valid at
//    BEATS+1; earliest next accept at BEATS+2.
//  - Little-endian beat order: beat 0 = least-significant BUS_W bits.
//  - data_ack_i ignored while stb low (IDLE/DONE); req_valid ignored while not IDLE.
//  - resp_rdata holds last value until the next load's beats overwrite it; stores
//    leave it unchanged.
// CONFIGURATION
//  CPU_LSU_TIMEOUT_EN defined: per-beat counter cleared at each beat start; if
//  TIMEOUT_CYC cycles pass in BUS without ack, stb/we drop, state DONE, resp_err=1
//  with resp_valid; un-received load beats are 0. Ack in the expiry cycle wins
//  (beat completes, no error). Undefined: no counter, waits indefinitely, resp_err
//  tied 0.
// TESTING
//  1 Load addr 0x0010, acks after 2 wait cycles, data 0xBEEF then 0xDEAD -> bus addr
//    0x0010 then 0x0011, we=0, resp_rdata=0xDEADBEEF, resp_err=0, one resp_valid pulse.
//  2 Store 0x12345678 to 0x0040, zero-wait ack -> data_data_o 0x5678 @0x0040 then
//    0x1234 @0x0041, we=1, resp_valid at cycle 3, req_ready high at cycle 4.
//  3 Load addr 0xFFFF -> second beat address 0x0000 (wrap), rdata assembled correctly.
//  4 Assert sys_rst low mid beat 1 -> stb low same cycle, no resp_valid, next request
//    after release runs normally from beat 0.
//  5 CPU_LSU_TIMEOUT_EN, TIMEOUT_CYC=8, never ack -> stb drops after 8 BUS cycles,
//    resp_valid & resp_err=1, resp_rdata=0; repeat with ack on cycle 8 -> no error.
//  6 Ack pulses and req_valid during DONE/IDLE-with-stb-low -> no state change,
//    no extra capture, no second response.

Source files
------------

// File: rtl/cpu_lsu.sv
// cpu_lsu: load/store unit that runs one REG_W-wide core access as REG_W/BUS_W stb/ack bus beats.
// Defining CPU_LSU_TIMEOUT_EN adds a per-beat ack timeout that aborts the access with resp_err.
module cpu_lsu #(
  parameter int BUS_W       = 16,
  parameter int REG_W       = 32,
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [REG_W-1:0]  req_wdata,
  output logic              resp_valid,
  output logic [REG_W-1:0]  resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic [BUS_W-1:0]  data_data_o,
  input  logic [BUS_W-1:0]  data_data_i,
  output logic              data_stb_o,
  output logic              data_we_o,
  input  logic              data_ack_i
);

  localparam int BEATS  = REG_W / BUS_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    DONE
  } state_t;

  state_t             state, state_next;
  logic [BEAT_W-1:0]  beat, beat_next;
  logic [REG_W-1:0]   wdata_sh, wdata_sh_next;
  logic [ADDR_W-1:0]  addr_next;
  logic [BUS_W-1:0]   dout_next;
  logic               stb_next, we_next;
  logic [REG_W-1:0]   rdata_next;
  logic               resp_valid_next, resp_err_next;
  logic               timeout_hit;

`ifdef CPU_LSU_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;

  // Counts cycles of the outstanding beat; any ack restarts it for the next beat.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst)
      to_cnt <= '0;
    else if (state != BUS || data_ack_i)
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + TO_W'(1);
  end

  assign timeout_hit = (state == BUS) && !data_ack_i && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign timeout_hit = 1'b0;
`endif

  assign req_ready = (state == IDLE);

  always_comb begin
    state_next      = state;
    beat_next       = beat;
    wdata_sh_next   = wdata_sh;
    addr_next       = data_addr_o;
    dout_next       = data_data_o;
    stb_next        = data_stb_o;
    we_next         = data_we_o;
    rdata_next      = resp_rdata;
    resp_err_next   = 1'b0;

    unique case (state)
      IDLE: begin
        if (req_valid) begin
          state_next    = BUS;
          beat_next     = '0;
          wdata_sh_next = req_wdata;
          addr_next     = req_addr;
          dout_next     = req_wdata[BUS_W-1:0];
          stb_next      = 1'b1;
          we_next       = req_we;
        end
      end
      BUS: begin
        if (data_ack_i) begin
          if (!data_we_o) begin
            for (int b = 0; b < BEATS; b++)
              if (beat == BEAT_W'(b))
                rdata_next[b*BUS_W +: BUS_W] = data_data_i;
          end
          if (beat == LAST_BEAT) begin
            stb_next   = 1'b0;
            we_next    = 1'b0;
            state_next = DONE;
          end else begin
            // Store data is kept pre-shifted so the next slice is always the low bits.
            beat_next     = beat + BEAT_W'(1);
            addr_next     = data_addr_o + ADDR_W'(1);
            wdata_sh_next = wdata_sh >> BUS_W;
            dout_next     = wdata_sh_next[BUS_W-1:0];
          end
        end else if (timeout_hit) begin
          if (!data_we_o) begin
            for (int b = 0; b < BEATS; b++)
              if (BEAT_W'(b) >= beat)
                rdata_next[b*BUS_W +: BUS_W] = '0;
          end
          stb_next      = 1'b0;
          we_next       = 1'b0;
          state_next    = DONE;
          resp_err_next = 1'b1;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase

    resp_valid_next = (state_next == DONE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state       <= IDLE;
      beat        <= '0;
      wdata_sh    <= '0;
      data_addr_o <= '0;
      data_data_o <= '0;
      data_stb_o  <= 1'b0;
      data_we_o   <= 1'b0;
      resp_rdata  <= '0;
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
    end else begin
      state       <= state_next;
      beat        <= beat_next;
      wdata_sh    <= wdata_sh_next;
      data_addr_o <= addr_next;
      data_data_o <= dout_next;
      data_stb_o  <= stb_next;
      data_we_o   <= we_next;
      resp_rdata  <= rdata_next;
      resp_valid  <= resp_valid_next;
      resp_err    <= resp_err_next;
    end
  end

endmodule
